// File: rtl/uart_tx_serializer.sv
// Pops bytes from the transmit FIFO and serializes each one as an 8N1 UART frame on tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_enable,
    input  logic                 FfEmpty,
    input  logic [DATA_BITS-1:0] ff_data,
    output logic                 FfRdEn,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;
`endif

    state_t                 state;
    state_t                 state_next;
    logic                   tx_next;
    logic [CNT_W-1:0]       baud_cnt;
    logic [2:0]             bit_cnt;
    logic [DATA_BITS-1:0]   shift;
    logic                   bit_end;
`ifdef UART_TX_PARITY_EN
    logic                   parity;
`endif

    assign bit_end = (baud_cnt == BAUD_LAST);
    assign FfRdEn  = (state == IDLE) && tx_enable && !FfEmpty && !rst;
    assign busy    = (state != IDLE);
    assign tx_done = (state == STOP) && bit_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // tx is registered from the next-state value so the line level lines up with state
    always_comb begin
        state_next = state;
        tx_next    = tx;
        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (FfRdEn) state_next = FETCH;
            end
            FETCH: begin
                tx_next    = 1'b0;
                state_next = START;
            end
            START: begin
                if (bit_end) begin
                    tx_next    = shift[0];
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        tx_next    = parity;
                        state_next = PARITY;
`else
                        tx_next    = 1'b1;
                        state_next = STOP;
`endif
                    end else begin
                        tx_next = shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    tx_next    = 1'b1;
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                tx_next = 1'b1;
                if (bit_end) state_next = IDLE;
            end
            default: begin
                tx_next    = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            tx <= tx_next;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                end
                FETCH: begin
                    shift    <= ff_data;
                    baud_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                    parity   <= ^ff_data;
`endif
                end
                DATA: begin
                    baud_cnt <= bit_end ? '0 : baud_cnt + CNT_W'(1);
                    if (bit_end) begin
                        shift   <= {1'b0, shift[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                default: baud_cnt <= bit_end ? '0 : baud_cnt + CNT_W'(1);
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer with a small registered-read FIFO model.
// Parity frames are exercised when UART_TX_PARITY_EN is defined.
module tb_uart_tx_serializer;

    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_enable = 1'b0;
    logic       ff_empty;
    logic [7:0] ff_data = 8'hFF;
    logic       ff_rd_en;
    logic       tx;
    logic       busy;
    logic       tx_done;

    logic [7:0] mem [64];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int rd_cnt = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int low_cnt = 0;
    int checks = 0;
    int failures = 0;

    uart_tx_serializer #(.CLKS_PER_BIT(C), .DATA_BITS(8)) dut (
        .clk(clk), .rst(rst), .tx_enable(tx_enable), .FfEmpty(ff_empty),
        .ff_data(ff_data), .FfRdEn(ff_rd_en), .tx(tx), .busy(busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    assign ff_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (ff_rd_en) begin
            ff_data <= mem[rd_ptr[5:0]];
            rd_ptr  <= rd_ptr + 1;
            rd_cnt  <= rd_cnt + 1;
        end else begin
            ff_data <= 8'hFF;
        end
        if (busy)       busy_cnt <= busy_cnt + 1;
        if (tx_done)    done_cnt <= done_cnt + 1;
        if (tx !== 1'b1) low_cnt <= low_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[5:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // Call at a negedge; waits for the start bit, then checks every cycle of the frame.
    task automatic expect_frame(input string tag, input logic [7:0] d, output int wait_n);
        logic [NB-1:0] bits;
        int match [NB];
        int done_ok;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
        bits[9] = ^d;
`endif
        bits[NB-1] = 1'b1;
        wait_n = 0;
        while (tx !== 1'b0 && wait_n < 200) begin
            @(negedge clk);
            wait_n++;
        end
        chk({tag, "_start"}, {31'd0, tx}, 32'd0);
        if (tx !== 1'b0) return;
        for (int b = 0; b < NB; b++) match[b] = 0;
        done_ok = 0;
        for (int j = 0; j < NB * C; j++) begin
            if (j > 0) @(negedge clk);
            if (tx === bits[j / C]) match[j / C]++;
            if (tx_done === (j == NB * C - 1)) done_ok++;
        end
        for (int b = 0; b < NB; b++) chk($sformatf("%s_bit%0d", tag, b), match[b], C);
        chk({tag, "_done"}, done_ok, NB * C);
    endtask

    int w, rd0, busy0, done0, low0;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_tx", {31'd0, tx}, 32'd1);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // asynchronous reset mid-cycle with a byte waiting and enable high
        tx_enable = 1'b1;
        #2 rst = 1'b1;
        push(8'h77);
        #1;
        chk("rst_rden", {31'd0, ff_rd_en}, 32'd0);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_done", {31'd0, tx_done}, 32'd0);
        wr_ptr = rd_ptr;
        @(negedge clk);
        rst = 1'b0;
        rd0 = rd_cnt; busy0 = busy_cnt; low0 = low_cnt;
        repeat (100) @(negedge clk);
        chk("empty_pops", rd_cnt - rd0, 0);
        chk("empty_busy", busy_cnt - busy0, 0);
        chk("empty_low", low_cnt - low0, 0);

        // single byte
        rd0 = rd_cnt; busy0 = busy_cnt; done0 = done_cnt;
        push(8'h55);
        expect_frame("b55", 8'h55, w);
        chk("b55_latency", w, 2);
        repeat (5) @(negedge clk);
        chk("b55_pops", rd_cnt - rd0, 1);
        chk("b55_busy", busy_cnt - busy0, NB * C + 1);
        chk("b55_donecnt", done_cnt - done0, 1);

        // back-to-back
        rd0 = rd_cnt;
        push(8'hA3);
        push(8'h0F);
        expect_frame("bA3", 8'hA3, w);
        chk("bA3_latency", w, 2);
        expect_frame("b0F", 8'h0F, w);
        chk("b0F_gap", w - 1, 2);
        repeat (5) @(negedge clk);
        chk("b2b_pops", rd_cnt - rd0, 2);

        // enable gating with 3 bytes queued
        rd0 = rd_cnt;
        push(8'h3C);
        push(8'h81);
        push(8'h5A);
        fork
            expect_frame("g3C", 8'h3C, w);
            begin
                repeat (2 + 4 * C + 1) @(negedge clk);
                tx_enable = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        chk("gate_pops", rd_cnt - rd0, 1);
        chk("gate_busy", {31'd0, busy}, 32'd0);
        chk("gate_tx", {31'd0, tx}, 32'd1);
        tx_enable = 1'b1;
        expect_frame("g81", 8'h81, w);
        chk("g81_latency", w, 2);
        expect_frame("g5A", 8'h5A, w);
        chk("g5A_gap", w - 1, 2);
        repeat (5) @(negedge clk);
        chk("gate_pops_total", rd_cnt - rd0, 3);

        // reset during data bit 5 of 0xFF
        rd0 = rd_cnt;
        push(8'hFF);
        repeat (2) @(negedge clk);
        chk("rstmid_start", {31'd0, tx}, 32'd0);
        repeat (6 * C + 1) @(negedge clk);
        chk("rstmid_busy_before", {31'd0, busy}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rstmid_tx", {31'd0, tx}, 32'd1);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_done", {31'd0, tx_done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        push(8'h12);
        expect_frame("b12", 8'h12, w);
        chk("b12_latency", w, 2);
        repeat (5) @(negedge clk);
        chk("rstmid_pops", rd_cnt - rd0, 2);

`ifdef UART_TX_PARITY_EN
        push(8'h55);
        expect_frame("p55", 8'h55, w);
        push(8'h07);
        expect_frame("p07", 8'h07, w);
        repeat (3) @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Downstream consumer of the UART transmit sync_fifo (8-bit wide, registered read data).
- Pops one byte at a time when the FIFO is non-empty and enabled.
- Serializes each byte as an 8N1 UART frame: start bit, 8 data bits LSB first, stop bit. Drives the tx pin of the UART block.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (clock freq / baud); legal range >= 2.
- DATA_BITS, 8, data bits per frame; fixed to 8 to match the FIFO width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- tx_enable  input  1  1 = block may pop new bytes; a frame in progress always completes.
- FfEmpty  input  1  FIFO empty flag.
- ff_data  input  8  FIFO read data; valid the cycle after FfRdEn=1 was sampled with FfEmpty=0.
- FfRdEn  output  1  FIFO read strobe, combinational.
- tx  output  1  serial line, registered; idles high.
- busy  output  1  1 in every state except IDLE.
- tx_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset:
  - Asserting rst forces state=IDLE, tx=1, busy=0, tx_done=0, baud_cnt=0, bit_cnt=0, shift register=0x00 immediately, without waiting for a clock edge.
  - FfRdEn=0 while in IDLE with rst asserted.
  - Reset mid-frame truncates the frame (line returns high at once). The popped byte is lost; it is not re-read.
- FfRdEn:
  - Equals (state==IDLE) && tx_enable && !FfEmpty && !rst.
  - Never asserted in any other state, so at most one pop per frame.
- States: IDLE, FETCH, START, DATA, STOP.
  - IDLE: tx=1. If FfRdEn=1 at the edge, go to FETCH.
  - FETCH (1 cycle): latch ff_data into an 8-bit shift register, clear baud_cnt, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right by one. bit_cnt counts 0..7; after bit 7 go to STOP (or PARITY, see Optional Feature).
  - STOP: tx=1 for CLKS_PER_BIT cycles. tx_done=1 on its final cycle, then go to IDLE.
- baud_cnt:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1; wraps to 0 at each bit boundary.
- Latency and gaps:
  - FfRdEn high at cycle N → FETCH at N+1 → tx falls at the edge ending N+1 (start bit visible from cycle N+2).
  - Frame length = 10*CLKS_PER_BIT cycles of tx, start through stop.
  - Back-to-back frames: IDLE and FETCH each add one cycle, so 2 extra cycles of tx=1 follow every stop bit.
- tx_enable:
  - Dropping it mid-frame has no effect on the current frame.
  - The block stays in IDLE afterwards until tx_enable returns.
- FIFO boundaries:
  - FfEmpty=1 in IDLE: no pop, tx stays 1, busy stays 0.
  - FIFO going empty or full during a frame is ignored; the byte is already latched.
- ff_data is sampled only in FETCH; its value in any other cycle (e.g. 0xFF when no read) is don't-care.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP.
  - tx = even parity bit (XOR of the 8 latched data bits) for CLKS_PER_BIT cycles.
  - Frame length becomes 11*CLKS_PER_BIT.
  - Parity is computed at FETCH from ff_data, not from the shifted register.
- Undefined:
  - No PARITY state or parity logic is synthesized; frame is 8N1 as above.

Test Plan:
- Reset/idle: CLKS_PER_BIT=4, assert rst asynchronously mid-cycle → tx=1, busy=0, tx_done=0, FfRdEn=0 immediately. Release with FfEmpty=1 → no pop over 100 cycles.
- Single byte: FIFO holds 0x55, tx_enable=1 →
  - FfRdEn high exactly 1 cycle.
  - tx = 0, then 1,0,1,0,1,0,1,0, then 1, each held 4 cycles (40 cycles).
  - tx_done pulses once on cycle 40; busy=1 for 41 cycles (FETCH plus frame).
- Back-to-back: FIFO holds 0xA3, 0x0F →
  - Two frames, data LSB first: 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0.
  - Exactly 2 high cycles between stop end and next start; FfRdEn pulses twice total.
- Enable gating: drop tx_enable at bit 3 of frame 1 with 3 bytes queued → frame 1 completes intact, no further FfRdEn. Re-raise → byte 2 starts 2 cycles later.
- Reset mid-frame: assert rst during DATA bit 5 of 0xFF → tx=1 immediately, state IDLE. After release with FIFO holding 0x12 → next frame transmits 0x12 cleanly.
- UART_TX_PARITY_EN defined: send 0x55 → parity bit 0; send 0x07 → parity bit 1. Each frame is 44 cycles at CLKS_PER_BIT=4.
